// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - request, memory-read and response/exception bundle for load_align_unit
interface load_align_unit_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              mem_rd;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              exc_valid;
    logic [1:0]        exc_code;
    logic [31:0]       exc_addr;

    modport master (
        output req_valid, req_addr, req_size, req_signed, mem_rdata,
        input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data,
               exc_valid, exc_code, exc_addr
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_signed, mem_rdata,
        output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data,
               exc_valid, exc_code, exc_addr
    );
endinterface

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load alignment unit: word read, byte extraction, extension, exceptions
// Optional: LOAD_ALIGN_UNALIGNED_EN completes misaligned loads, splitting word-crossing ones into two reads.
module load_align_unit #(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    load_align_unit_if.slave bus
);
    localparam int         NBYTES = DATA_W / 8;
    localparam int         OFF_W  = $clog2(NBYTES);
    localparam logic [3:0] LAT    = 4'(MEM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        EXC
`ifdef LOAD_ALIGN_UNALIGNED_EN
        ,
        ISSUE2,
        WAIT2
`endif
    } state_t;

    function automatic logic size_illegal(input logic [1:0] size);
        return (size == 2'd3) && (DATA_W == 32);
    endfunction

    function automatic logic addr_misaligned(input logic [31:0] addr, input logic [1:0] size);
        logic m;
        case (size)
            2'd1:    m = addr[0];
            2'd2:    m = |addr[1:0];
            2'd3:    m = |addr[2:0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Shift the addressed bytes down, then push the field to the top and back so the
    // right shift either zero-fills or replicates the field's sign bit.
    function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] raw,
                                                  input logic [OFF_W-1:0]    off,
                                                  input logic [1:0]          size,
                                                  input logic                sgn);
        logic [2*DATA_W-1:0] shifted;
        logic [DATA_W-1:0]   field;
        logic [6:0]          pad;
        shifted = raw >> {off, 3'b000};
        field   = shifted[DATA_W-1:0];
        pad     = 7'(DATA_W - (8 << size));
        field   = field << pad;
        if (sgn) field = $signed(field) >>> pad;
        else     field = field >> pad;
        return field;
    endfunction

`ifdef LOAD_ALIGN_UNALIGNED_EN
    function automatic logic crosses(input logic [31:0] addr, input logic [1:0] size);
        return (int'(addr[OFF_W-1:0]) + (1 << size)) > NBYTES;
    endfunction
`endif

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [31:0]       mem_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        exc_code_q;
    logic [31:0]       exc_addr_q;
    logic              req_illegal;
    logic              req_bad;
    logic              req_ready_c, mem_rd_c, rsp_valid_c, exc_valid_c;
`ifdef LOAD_ALIGN_UNALIGNED_EN
    logic              cross_q;
    logic [DATA_W-1:0] word_a;
`endif

    assign req_illegal = size_illegal(bus.req_size);
`ifdef LOAD_ALIGN_UNALIGNED_EN
    assign req_bad = req_illegal;
`else
    assign req_bad = req_illegal || addr_misaligned(bus.req_addr, bus.req_size);
`endif

    always_comb begin
        state_n     = state;
        req_ready_c = 1'b0;
        mem_rd_c    = 1'b0;
        rsp_valid_c = 1'b0;
        exc_valid_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_n = req_bad ? EXC : ISSUE;
            end
            ISSUE: begin
                mem_rd_c = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd1) begin
`ifdef LOAD_ALIGN_UNALIGNED_EN
                    state_n = cross_q ? ISSUE2 : DONE;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef LOAD_ALIGN_UNALIGNED_EN
            ISSUE2: begin
                mem_rd_c = 1'b1;
                state_n  = WAIT2;
            end
            WAIT2: begin
                if (cnt == 4'd1) state_n = DONE;
            end
`endif
            DONE: begin
                rsp_valid_c = 1'b1;
                state_n     = IDLE;
            end
            EXC: begin
                exc_valid_c = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes are masked by reset so an aborted load cannot leak a pulse in the reset cycle.
    assign bus.req_ready = req_ready_c & ~reset;
    assign bus.mem_rd    = mem_rd_c & ~reset;
    assign bus.rsp_valid = rsp_valid_c & ~reset;
    assign bus.exc_valid = exc_valid_c & ~reset;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.exc_code  = exc_code_q;
    assign bus.exc_addr  = exc_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            off_q      <= '0;
            size_q     <= 2'd0;
            sgn_q      <= 1'b0;
            mem_addr_q <= 32'd0;
            rsp_data_q <= '0;
            exc_code_q <= 2'd0;
            exc_addr_q <= 32'd0;
`ifdef LOAD_ALIGN_UNALIGNED_EN
            cross_q    <= 1'b0;
            word_a     <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q  <= bus.req_addr[OFF_W-1:0];
                        size_q <= bus.req_size;
                        sgn_q  <= bus.req_signed;
`ifdef LOAD_ALIGN_UNALIGNED_EN
                        cross_q <= crosses(bus.req_addr, bus.req_size);
`endif
                        if (req_bad) begin
                            exc_code_q <= req_illegal ? 2'b10 : 2'b01;
                            exc_addr_q <= bus.req_addr;
                        end else begin
                            mem_addr_q <= {bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                ISSUE: cnt <= LAT;
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
`ifdef LOAD_ALIGN_UNALIGNED_EN
                        if (cross_q) begin
                            word_a     <= bus.mem_rdata;
                            mem_addr_q <= mem_addr_q + 32'(NBYTES);
                        end else
`endif
                        rsp_data_q <= extract({{DATA_W{1'b0}}, bus.mem_rdata}, off_q, size_q, sgn_q);
                    end
                end
`ifdef LOAD_ALIGN_UNALIGNED_EN
                ISSUE2: cnt <= LAT;
                WAIT2: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        rsp_data_q <= extract({bus.mem_rdata, word_a}, off_q, size_q, sgn_q);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - self-checking bench for load_align_unit against a byte-level load model
module tb_load_align_unit;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef LOAD_ALIGN_UNALIGNED_EN
    localparam bit UNAL = 1'b1;
`else
    localparam bit UNAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    load_align_unit_if #(.DATA_W(DW)) bus ();
    load_align_unit #(.DATA_W(DW), .MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit in_reset = 1'b1;
    int free_cyc = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd  [int];
    logic [31:0] exp_rsp [int];
    logic [33:0] exp_exc [int];
    logic [31:0] last_rsp = 0, last_maddr = 0, last_eaddr = 0;
    logic [1:0]  last_code = 0;
    int          pend_due [$];
    logic [31:0] pend_addr [$];

    int acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_cyc = 0, exc_cnt = 0, exc_cyc = 0, rd_cnt = 0;
    int          rd_cyc [2];
    logic [31:0] rd_addr [2];
    logic [31:0] rsp_seen = 0, exc_addr_seen = 0;
    logic [1:0]  exc_code_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = get_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Load semantics straight from the rules: gather bytes little-endian, extend, schedule events.
    task automatic model_accept(input logic [31:0] a, input logic [1:0] sz, input logic sg, input int t);
        int                nb;
        logic [63:0]       v;
        logic [31:0]       w0;
        nb = 1 << sz;
        if (DW == 32 && sz == 2'd3) begin
            exp_exc[t+1] = {2'b10, a};
            free_cyc = t + 2;
        end else if ((int'(a[7:0]) % nb) != 0 && !UNAL) begin
            exp_exc[t+1] = {2'b01, a};
            free_cyc = t + 2;
        end else begin
            v = 64'd0;
            for (int i = 0; i < nb; i++) v = v | (64'(mem_byte(a + 32'(i))) << (8 * i));
            if (sg && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
            w0 = {a[31:2], 2'b00};
            exp_rd[t+1] = w0;
            if (int'(a[1:0]) + nb > 4) begin
                exp_rd[t+2+LAT]    = w0 + 32'd4;
                exp_rsp[t+3+2*LAT] = v[31:0];
                free_cyc = t + 4 + 2 * LAT;
            end else begin
                exp_rsp[t+2+LAT] = v[31:0];
                free_cyc = t + 3 + LAT;
            end
        end
    endtask

    // Memory: answers each read exactly LAT cycles later, garbage otherwise.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.mem_rd) begin
            pend_due.push_back(cyc + LAT);
            pend_addr.push_back(bus.mem_addr);
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            bus.mem_rdata = get_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        if (in_reset) begin
            chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
            chk("strobes_in_reset", 64'({bus.mem_rd, bus.rsp_valid, bus.exc_valid}), 64'd0);
            exp_rd.delete();
            exp_rsp.delete();
            exp_exc.delete();
            last_rsp = 0; last_maddr = 0; last_eaddr = 0; last_code = 0;
        end else begin
            chk("req_ready", 64'(bus.req_ready), 64'(cyc >= free_cyc));
            chk("mem_rd", 64'(bus.mem_rd), 64'(exp_rd.exists(cyc)));
            if (exp_rd.exists(cyc)) begin
                last_maddr = exp_rd[cyc];
                exp_rd.delete(cyc);
            end
            chk("mem_addr", 64'(bus.mem_addr), 64'(last_maddr));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp.exists(cyc)));
            if (exp_rsp.exists(cyc)) begin
                last_rsp = exp_rsp[cyc];
                exp_rsp.delete(cyc);
            end
            chk("rsp_data", 64'(bus.rsp_data), 64'(last_rsp));
            chk("exc_valid", 64'(bus.exc_valid), 64'(exp_exc.exists(cyc)));
            if (exp_exc.exists(cyc)) begin
                {last_code, last_eaddr} = exp_exc[cyc];
                exp_exc.delete(cyc);
            end
            chk("exc_code", 64'(bus.exc_code), 64'(last_code));
            chk("exc_addr", 64'(bus.exc_addr), 64'(last_eaddr));
            if (bus.rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_seen = bus.rsp_data; end
            if (bus.exc_valid) begin exc_cnt++; exc_cyc = cyc; exc_code_seen = bus.exc_code; exc_addr_seen = bus.exc_addr; end
            if (bus.mem_rd) begin
                if (rd_cnt < 2) begin rd_cyc[rd_cnt] = cyc; rd_addr[rd_cnt] = bus.mem_addr; end
                rd_cnt++;
            end
            if (cyc >= free_cyc && bus.req_valid) begin
                acc_cnt++;
                acc_cyc = cyc;
                rd_cnt = 0;
                model_accept(bus.req_addr, bus.req_size, bus.req_signed, cyc);
            end
        end
    end

    task automatic present(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int start, n;
        start = acc_cnt;
        n = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_size = sz; bus.req_signed = sg;
        while (acc_cnt == start && n < 40) begin @(negedge clk); n++; end
        chk("accepted", 64'(acc_cnt - start), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n;
        present(a, sz, sg);
        n = 0;
        while (cyc < free_cyc && n < 60) begin @(posedge clk); #1; n++; end
        chk("load_finished", 64'(cyc >= free_cyc), 64'd1);
    endtask

    initial begin
        int r0, e0, n;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; in_reset = 1'b0; free_cyc = cyc;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_exc", 64'({bus.exc_code, bus.exc_addr, bus.mem_addr}), 64'd0);

        mem[32'h1000] = 32'h80FF1234;
        do_load(32'h1003, 2'd0, 1'b1);
        chk("t1_data", 64'(rsp_seen), 64'hFFFFFF80);
        chk("t1_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd4);
        chk("t1_rd_lat", 64'(rd_cyc[0] - acc_cyc), 64'd1);
        chk("t1_rd_addr", 64'(rd_addr[0]), 64'h1000);
        do_load(32'h1002, 2'd1, 1'b0);
        chk("t2_uhalf", 64'(rsp_seen), 64'h000080FF);
        do_load(32'h1000, 2'd1, 1'b1);
        chk("t2_shalf", 64'(rsp_seen), 64'h00001234);

`ifndef LOAD_ALIGN_UNALIGNED_EN
        r0 = rsp_cnt;
        do_load(32'h1006, 2'd2, 1'b0);
        chk("t3_exc_lat", 64'(exc_cyc - acc_cyc), 64'd1);
        chk("t3_code", 64'(exc_code_seen), 64'd1);
        chk("t3_addr", 64'(exc_addr_seen), 64'h1006);
        chk("t3_no_rd", 64'(rd_cnt), 64'd0);
        chk("t3_no_rsp", 64'(rsp_cnt - r0), 64'd0);
`else
        mem[32'h1000] = 32'hAABBCCDD;
        mem[32'h1004] = 32'h11223344;
        do_load(32'h1002, 2'd2, 1'b0);
        chk("t6_data", 64'(rsp_seen), 64'h3344AABB);
        chk("t6_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd7);
        chk("t6_rd2_lat", 64'(rd_cyc[1] - acc_cyc), 64'd4);
        chk("t6_rd2_addr", 64'(rd_addr[1]), 64'h1004);
`endif

        do_load(32'h2000, 2'd3, 1'b1);
        chk("t4_exc_lat", 64'(exc_cyc - acc_cyc), 64'd1);
        chk("t4_code", 64'(exc_code_seen), 64'd2);
        chk("t4_addr", 64'(exc_addr_seen), 64'h2000);

        present(32'h1000, 2'd2, 1'b0);
        @(posedge clk); #1;
        r0 = rsp_cnt; e0 = exc_cnt;
        reset = 1'b1; in_reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_reset = 1'b0; free_cyc = cyc;
        @(negedge clk);
        chk("t5_ready_after_reset", 64'(bus.req_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("t5_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        chk("t5_no_exc", 64'(exc_cnt - e0), 64'd0);
        mem[32'h0] = 32'h5A5A5AC3;
        do_load(32'h0, 2'd0, 1'b0);
        chk("t5_next_load", 64'(rsp_seen), 64'h000000C3);
        chk("t5_next_lat", 64'(rsp_cyc - acc_cyc), 64'd4);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (in_reset) begin
                reset = 1'b0; in_reset = 1'b0; free_cyc = cyc;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1; in_reset = 1'b1;
            end
            bus.req_valid  = ($urandom_range(0, 2) != 0);
            bus.req_addr   = 32'h4000 + 32'($urandom_range(0, 127));
            bus.req_size   = 2'($urandom_range(0, 3));
            bus.req_signed = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        if (in_reset) begin in_reset = 1'b0; free_cyc = cyc; end
        bus.req_valid = 1'b0;
        n = 0;
        while (cyc < free_cyc + 2 && n < 60) begin @(posedge clk); #1; n++; end
        chk("drain", 64'(cyc >= free_cyc), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised successor to the CPU's load-size stage.
- Accepts a load request (byte address, size, signed flag) and issues a word-aligned read to data memory.
- Waits a fixed memory latency, then extracts the addressed byte, halfword, word or dword and zero- or sign-extends it to DATA_W.
- Flags misaligned or illegal-size loads as exceptions.
- Sits between the multicycle control unit and data memory, and feeds the register-file write-back mux.

Parameters:
DATA_W, 32, memory/register data width; legal values 32 or 64. OFF_W = log2(DATA_W/8).
MEM_LAT, 2, cycles from mem_rd high to mem_rdata valid; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  load request present
req_ready  output  1  unit idle and able to accept a request
req_addr  input  32  byte address
req_size  input  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64)
req_signed  input  1  1 = sign-extend, 0 = zero-extend
mem_rd  output  1  one-cycle read strobe
mem_addr  output  32  read address, low OFF_W bits forced to 0
mem_rdata  input  DATA_W  read data, valid exactly MEM_LAT cycles after mem_rd
rsp_valid  output  1  one-cycle pulse, rsp_data updated
rsp_data  output  DATA_W  aligned, extended load result; holds until the next response
exc_valid  output  1  one-cycle exception pulse
exc_code  output  2  01 misaligned, 10 illegal size; held until the next exception
exc_addr  output  32  faulting address; held until the next exception

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- While reset is high, at the next edge:
  - FSM goes to IDLE.
  - mem_rd, rsp_valid and exc_valid are 0.
  - rsp_data, exc_code, exc_addr and mem_addr are 0.
  - The latency counter is 0.
  - req_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts the load: no rsp_valid, no exc_valid, no further mem_rd.
- Endianness is little-endian: byte offset k occupies mem_rdata[8k+7:8k].
- FSM states: IDLE, ISSUE, WAIT, DONE, EXC.
  - IDLE: req_ready=1. Accept on req_valid && req_ready (cycle T); latch addr, size and signed.
    - Illegal size (11 with DATA_W=32) -> EXC with code 10. Illegal size takes priority over misalignment.
    - Misaligned (addr bits [size-1:0] nonzero, with byte never misaligned) -> EXC with code 01.
    - Otherwise -> ISSUE.
  - ISSUE (T+1): mem_rd=1 and mem_addr = {addr[31:OFF_W], 0}. Counter loads MEM_LAT. -> WAIT.
  - WAIT: counter decrements each cycle. In cycle T+1+MEM_LAT, sample mem_rdata, shift right by 8*addr[OFF_W-1:0], mask to the size, and extend with the top bit of the field when signed. -> DONE.
  - DONE (T+2+MEM_LAT): rsp_valid=1 and rsp_data registered. -> IDLE.
  - EXC (T+1): exc_valid=1, exc_addr=latched addr, no mem_rd. -> IDLE.
- req_ready=0 in every state except IDLE; requests presented outside IDLE are ignored.
- rsp_valid and exc_valid are never high in the same cycle. There is no response backpressure.
- Back-to-back loads: the next accept can occur in the cycle after DONE or EXC, because the FSM is back in IDLE then.
- mem_addr holds its last value between reads.

Optional Feature:
Macro: LOAD_ALIGN_UNALIGNED_EN.
- Without it: misaligned loads raise exception code 01 as described above.
- With it: misaligned legal-size loads complete with no exception.
  - If the access lies within one DATA_W word: single read, normal timing.
  - If it crosses a word boundary:
    - First read at T+1 (word A), data sampled at T+1+MEM_LAT.
    - Second mem_rd at T+2+MEM_LAT with mem_addr = A + DATA_W/8; data sampled at T+2+2*MEM_LAT.
    - Bytes are merged, then extended; rsp_valid at T+3+2*MEM_LAT.
  - Extra states: ISSUE2 and WAIT2.
  - Illegal size still raises code 10.
  - Reset during either read aborts the whole load.

Test Plan:
1. DATA_W=32, MEM_LAT=2. Signed byte at 0x1003, mem word 0x80FF1234 -> mem_rd at T+1 with mem_addr 0x1000; rsp_valid at T+4; rsp_data 0xFFFFFF80.
2. Unsigned half at 0x1002, word 0x80FF1234 -> rsp_data 0x000080FF. Then signed half at 0x1000, same word -> 0x00001234.
3. Word at 0x1006, macro off -> exc_valid at T+1, exc_code 01, exc_addr 0x1006, mem_rd never high, rsp_valid never high.
4. req_size=11 at 0x2000 with DATA_W=32 -> exc_code 10 at T+1. With DATA_W=64 and dword 0x2000 (rdata 0x8000000000000001, signed) -> rsp_data 0x8000000000000001 at T+4.
5. Reset pulsed at T+2 during WAIT -> no rsp_valid or exc_valid; req_ready=1 the cycle after reset drops; next byte load at 0x0 completes normally.
6. Macro on, MEM_LAT=2. Word at 0x1002, memory 0x1000=0xAABBCCDD and 0x1004=0x11223344 -> reads at T+1 (0x1000) and T+4 (0x1004); rsp_valid at T+7; rsp_data 0x3344AABB.
